store_narrow: RTL and testbench

//  Store-side counterpart of the immediate/load extender: narrows a 32-bit

---
 rtl/store_narrow_if.sv | 28 ++
 rtl/store_narrow.sv | 125 ++++++++++++
 tb/tb_store_narrow.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_narrow_if.sv
// Store request and byte-wide memory write port of the store narrowing unit.
// The slave modport is the unit itself; the master side is the core plus the data RAM.
interface store_narrow_if #(
    parameter int ADDR_W = 32
);
    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;
    logic [1:0]        st_size;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_byte;
    logic              mem_ack;
    logic              busy;
    logic              done;
    logic              align_err;

    modport slave (
        input  st_valid, st_addr, st_data, st_size, mem_ack,
        output st_ready, mem_wr, mem_addr, mem_byte, busy, done, align_err
    );

    modport master (
        output st_valid, st_addr, st_data, st_size, mem_ack,
        input  st_ready, mem_wr, mem_addr, mem_byte, busy, done, align_err
    );
endinterface

// File: rtl/store_narrow.sv
// Narrows a register value to byte/half/word and writes it big-endian, one byte
// per acknowledged beat, onto the byte-wide data RAM port.
//
// state | meaning
// IDLE  | ready for a store request; alignment checked on accept
// SEND  | driving beat beat_q of last_q+1 beats, waiting for mem_ack
module store_narrow #(
    parameter int ADDR_W = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    store_narrow_if.slave  bus_io
);
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       data_q, data_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [1:0]        beat_q, beat_d;
    logic [1:0]        last_q, last_d;
    logic              done_q, done_d;
    logic              align_err_q, align_err_d;

    logic              accept;
    logic              misaligned;
    logic [1:0]        byte_sel;
    logic [31:0]       shifted;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            data_q      <= '0;
            base_q      <= '0;
            beat_q      <= '0;
            last_q      <= '0;
            done_q      <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            base_q      <= base_d;
            beat_q      <= beat_d;
            last_q      <= last_d;
            done_q      <= done_d;
            align_err_q <= align_err_d;
        end
    end

    always_comb begin
        misaligned = 1'b1;
        unique case (bus_io.st_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = bus_io.st_addr[0];
            2'b10:   misaligned = |bus_io.st_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    assign accept = bus_io.st_valid && (state_q == IDLE);

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        base_d      = base_q;
        beat_d      = beat_q;
        last_d      = last_q;
        done_d      = 1'b0;
        align_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        align_err_d = 1'b1;
                    end else begin
                        state_d = SEND;
                        base_d  = bus_io.st_addr;
                        beat_d  = 2'd0;
                        // Truncate now so later beats never see stale upper bytes.
                        unique case (bus_io.st_size)
                            2'b00: begin
                                data_d = {24'h0, bus_io.st_data[7:0]};
                                last_d = 2'd0;
                            end
                            2'b01: begin
                                data_d = {16'h0, bus_io.st_data[15:0]};
                                last_d = 2'd1;
                            end
                            default: begin
                                data_d = bus_io.st_data;
                                last_d = 2'd3;
                            end
                        endcase
                    end
                end
            end
            SEND: begin
                if (bus_io.mem_ack) begin
                    if (beat_q == last_q) begin
                        state_d = IDLE;
                        beat_d  = 2'd0;
                        done_d  = 1'b1;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Big-endian: first beat carries the most significant stored byte.
    assign byte_sel = last_q - beat_q;
    assign shifted  = data_q >> {byte_sel, 3'b000};

    assign bus_io.st_ready  = (state_q == IDLE) && !rst_i;
    assign bus_io.mem_wr    = (state_q == SEND);
    assign bus_io.busy      = (state_q == SEND);
    assign bus_io.mem_addr  = (state_q == SEND) ? base_q + ADDR_W'(beat_q) : '0;
    assign bus_io.mem_byte  = (state_q == SEND) ? shifted[7:0] : 8'h00;
    assign bus_io.done      = done_q;
    assign bus_io.align_err = align_err_q;
endmodule

// File: tb/tb_store_narrow.sv
// Scoreboarded bench for store_narrow: expected beats are queued at issue time
// and checked by a monitor as the memory side acknowledges them.
module tb_store_narrow;
    localparam int ADDR_W = 32;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic ack_r = 1'b0;

    store_narrow_if #(.ADDR_W(ADDR_W)) bus ();

    store_narrow #(.ADDR_W(ADDR_W)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .bus_io (bus.slave)
    );

    always #5 clk_i = ~clk_i;
    assign bus.mem_ack = ack_r;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
        int          hold;
    } beat_t;

    beat_t exp_q[$];
    int nvec = 0;
    int nerr = 0;
    int done_cnt = 0;
    int aerr_cnt = 0;
    int beat_cnt = 0;
    int cyc_ctr = 0;
    int ack_wait = 0;
    logic ack_idle = 1'b0;
    int wait_cnt = 0;
    int hold = 0;

    always @(posedge clk_i) cyc_ctr++;

    // Memory model: holds ack low for ack_wait cycles of each beat.
    always @(posedge clk_i) begin
        #1;
        if (bus.mem_wr) begin
            if (wait_cnt >= ack_wait) begin
                ack_r = 1'b1;
                wait_cnt = 0;
            end else begin
                ack_r = 1'b0;
                wait_cnt++;
            end
        end else begin
            ack_r = ack_idle;
            wait_cnt = 0;
        end
    end

    always @(negedge clk_i) begin
        if (bus.done) done_cnt++;
        if (bus.align_err) aerr_cnt++;
        if (bus.done && bus.align_err) begin
            nerr++;
            $display("FAIL done_align_overlap: both high at cycle %0d", cyc_ctr);
        end
        if (bus.mem_wr) begin
            hold++;
            if (bus.mem_ack) begin
                beat_t e;
                beat_cnt++;
                nvec++;
                if (exp_q.size() == 0) begin
                    nerr++;
                    $display("FAIL beat_unexpected: got addr %h byte %h", bus.mem_addr, bus.mem_byte);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.mem_addr, bus.mem_byte} !== {e.addr, e.data} || hold != e.hold || bus.busy !== 1'b1) begin
                        nerr++;
                        $display("FAIL beat: got addr %h byte %h hold %0d busy %b, want addr %h byte %h hold %0d busy 1",
                                 bus.mem_addr, bus.mem_byte, hold, bus.busy, e.addr, e.data, e.hold);
                    end
                end
                hold = 0;
            end
        end else begin
            hold = 0;
        end
    end

    task automatic issue(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size,
                         output int acc_cyc);
        bit ok;
        bit legal;
        int beats;
        legal = !((size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00));
        beats = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        if (legal) begin
            for (int k = 0; k < beats; k++) begin
                beat_t e;
                e.addr = addr + 32'(k);
                e.data = 8'(data >> (8 * (beats - 1 - k)));
                e.hold = ack_wait + 1;
                exp_q.push_back(e);
            end
        end
        bus.st_valid = 1'b1;
        bus.st_addr  = addr;
        bus.st_data  = data;
        bus.st_size  = size;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk_i);
            ok = bus.st_ready;
            @(posedge clk_i);
            #1;
        end
        acc_cyc = cyc_ctr;
        bus.st_valid = 1'b0;
        bus.st_addr  = ~addr;
        bus.st_data  = ~data;
        bus.st_size  = size + 2'd1;
        nvec++;
        if (!ok) begin
            nerr++;
            $display("FAIL accept_timeout: st_ready %b, want 1 within 200 cycles", bus.st_ready);
        end
    endtask

    task automatic wait_done(output int cyc);
        bit seen;
        seen = 1'b0;
        cyc = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk_i);
            cyc++;
            seen = bus.done;
        end
        @(posedge clk_i);
        #1;
        if (!seen) cyc = -1;
    endtask

    task automatic test_reset();
        #2;
        nvec++;
        if ({bus.st_ready, bus.mem_wr, bus.busy, bus.done, bus.align_err, bus.mem_addr, bus.mem_byte} !== '0) begin
            nerr++;
            $display("FAIL reset_outputs: rdy %b wr %b busy %b done %b aerr %b addr %h byte %h, want all 0",
                     bus.st_ready, bus.mem_wr, bus.busy, bus.done, bus.align_err, bus.mem_addr, bus.mem_byte);
        end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        nvec++;
        if (bus.st_ready !== 1'b1) begin
            nerr++;
            $display("FAIL reset_release_ready: got %b want 1", bus.st_ready);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_word();
        int acc, cyc, b0;
        ack_wait = 0;
        ack_idle = 1'b1;
        b0 = beat_cnt;
        issue(32'h100, 32'h1122_3344, 2'b10, acc);
        wait_done(cyc);
        nvec++;
        if (cyc != 5 || beat_cnt - b0 != 4 || exp_q.size() != 0) begin
            nerr++;
            $display("FAIL word_done: latency %0d beats %0d left %0d, want 5 4 0", cyc, beat_cnt - b0, exp_q.size());
        end
    endtask

    task automatic test_byte();
        int acc, cyc;
        issue(32'h203, 32'hDEAD_BEEF, 2'b00, acc);
        wait_done(cyc);
        nvec++;
        if (cyc != 2 || exp_q.size() != 0) begin
            nerr++;
            $display("FAIL byte_done: latency %0d left %0d, want 2 0", cyc, exp_q.size());
        end
    endtask

    task automatic test_half_stall();
        int acc, cyc, d0;
        ack_wait = 3;
        ack_idle = 1'b0;
        d0 = done_cnt;
        issue(32'h10, 32'hFFFF_8001, 2'b01, acc);
        wait_done(cyc);
        repeat (3) @(posedge clk_i);
        #1;
        nvec++;
        if (cyc != 9 || done_cnt - d0 != 1 || exp_q.size() != 0) begin
            nerr++;
            $display("FAIL half_stall: latency %0d dones %0d left %0d, want 9 1 0", cyc, done_cnt - d0, exp_q.size());
        end
    endtask

    task automatic test_align_err();
        logic [31:0] addrs [3];
        logic [1:0]  sizes [3];
        int acc, a0;
        addrs = '{32'h11, 32'h22, 32'h40};
        sizes = '{2'b01, 2'b10, 2'b11};
        ack_wait = 0;
        ack_idle = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a0 = aerr_cnt;
            issue(addrs[i], 32'h5555_AAAA, sizes[i], acc);
            @(negedge clk_i);
            nvec++;
            if (bus.align_err !== 1'b1 || bus.mem_wr !== 1'b0 || bus.st_ready !== 1'b1 || bus.done !== 1'b0) begin
                nerr++;
                $display("FAIL align_pulse[%0d]: aerr %b wr %b rdy %b done %b, want 1 0 1 0",
                         i, bus.align_err, bus.mem_wr, bus.st_ready, bus.done);
            end
            @(negedge clk_i);
            nvec++;
            if (bus.align_err !== 1'b0 || bus.mem_wr !== 1'b0 || aerr_cnt - a0 != 1 || exp_q.size() != 0) begin
                nerr++;
                $display("FAIL align_after[%0d]: aerr %b wr %b pulses %0d left %0d, want 0 0 1 0",
                         i, bus.align_err, bus.mem_wr, aerr_cnt - a0, exp_q.size());
            end
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic test_wrap();
        int acc, cyc, a0;
        a0 = aerr_cnt;
        issue(32'hFFFF_FFFE, 32'h0102_0304, 2'b10, acc);
        repeat (2) @(posedge clk_i);
        #1;
        nvec++;
        if (aerr_cnt - a0 != 1 || exp_q.size() != 0) begin
            nerr++;
            $display("FAIL wrap_word_err: pulses %0d left %0d, want 1 0", aerr_cnt - a0, exp_q.size());
        end
        issue(32'hFFFF_FFFE, 32'h0000_ABCD, 2'b01, acc);
        wait_done(cyc);
        nvec++;
        if (cyc != 3 || exp_q.size() != 0) begin
            nerr++;
            $display("FAIL wrap_half: latency %0d left %0d, want 3 0", cyc, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int acc1, acc2, d0;
        ack_wait = 0;
        d0 = done_cnt;
        issue(32'h50, 32'h0000_00A5, 2'b00, acc1);
        issue(32'h60, 32'h0000_1234, 2'b01, acc2);
        repeat (6) @(posedge clk_i);
        #1;
        nvec++;
        if (acc2 - acc1 != 2 || done_cnt - d0 != 2 || exp_q.size() != 0) begin
            nerr++;
            $display("FAIL back_to_back: gap %0d dones %0d left %0d, want 2 2 0", acc2 - acc1, done_cnt - d0, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int acc, cyc, d0, a0;
        ack_wait = 3;
        ack_idle = 1'b0;
        issue(32'h300, 32'hCAFE_F00D, 2'b10, acc);
        repeat (9) @(posedge clk_i);
        #1;
        nvec++;
        if (bus.mem_addr !== 32'h302 || bus.mem_wr !== 1'b1) begin
            nerr++;
            $display("FAIL mid_beat2: addr %h wr %b, want 00000302 1", bus.mem_addr, bus.mem_wr);
        end
        d0 = done_cnt;
        a0 = aerr_cnt;
        rst_i = 1'b1;
        #1;
        nvec++;
        if (bus.mem_wr !== 1'b0 || bus.busy !== 1'b0 || bus.st_ready !== 1'b0 || exp_q.size() != 2) begin
            nerr++;
            $display("FAIL mid_reset: wr %b busy %b rdy %b left %0d, want 0 0 0 2",
                     bus.mem_wr, bus.busy, bus.st_ready, exp_q.size());
        end
        exp_q.delete();
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        ack_wait = 0;
        issue(32'h400, 32'h0000_0077, 2'b00, acc);
        wait_done(cyc);
        nvec++;
        if (cyc != 2 || done_cnt - d0 != 1 || aerr_cnt - a0 != 0 || exp_q.size() != 0) begin
            nerr++;
            $display("FAIL after_reset_sb: latency %0d dones %0d aerrs %0d left %0d, want 2 1 0 0",
                     cyc, done_cnt - d0, aerr_cnt - a0, exp_q.size());
        end
    endtask

    initial begin
        bus.st_valid = 1'b0;
        bus.st_addr  = '0;
        bus.st_data  = '0;
        bus.st_size  = 2'b00;
        test_reset();
        test_word();
        test_byte();
        test_half_stall();
        test_align_err();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end
endmodule
